// File: rtl/vdp18_pkg.sv
// Shared types and constants for the VDP18 sprite VRAM access sequencer.
//   access_t          : VRAM access kind presented to the sprite controller
//   state_t           : sprite access sequencer states
//   phase_t           : progress of the slot currently in flight
//   hv_sprite_start_c : pixel at which sprite attribute/pattern reads begin
package vdp18_pkg;

  typedef enum logic [2:0] {
    AC_NONE,
    AC_STST,
    AC_SATY,
    AC_SATX,
    AC_SATN,
    AC_SATC,
    AC_SPTH,
    AC_SPTL
  } access_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TEST,
    ST_WAIT_RD,
    ST_READ,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_FREE,
    PH_REQ,
    PH_ACC
  } phase_t;

  localparam int unsigned stst_cnt_w_c = 6;
  localparam int unsigned stst_max_c   = 32;
  localparam int unsigned vram_aw_c    = 14;

  // Reads start in the horizontal blanking region, after the last test slot.
  localparam logic signed [8:0] hv_sprite_start_c = -9'sd120;

  // Next access in the per-sprite read sequence, given the one just issued.
  function automatic access_t read_next(input access_t cur, input logic size1);
    access_t nxt;
    nxt = AC_SATY;
    case (cur)
      AC_SATY: nxt = AC_SATX;
      AC_SATX: nxt = AC_SATN;
      AC_SATN: nxt = AC_SATC;
      AC_SATC: nxt = AC_SPTH;
      AC_SPTH: nxt = size1 ? AC_SPTL : AC_SATY;
      default: nxt = AC_SATY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vdp18_spr_addr.sv
// Combinational VRAM address former for sprite accesses.
// Ports:
//   access_type : kind of access being requested
//   satb, spgb  : attribute table / pattern generator base registers
//   size1       : 16x16 sprite mode
//   spr_num, spr_line, spr_name : sprite fields from the sprite controller
//   addr_c      : resulting 14-bit VRAM address
module vdp18_spr_addr
  import vdp18_pkg::*;
(
  input  access_t     access_type,
  input  logic [6:0]  satb,
  input  logic [2:0]  spgb,
  input  logic        size1,
  input  logic [4:0]  spr_num,
  input  logic [3:0]  spr_line,
  input  logic [7:0]  spr_name,
  output logic [13:0] addr_c
);

  // Attribute entries are 4 bytes per sprite; patterns are 8 or 32 bytes.
  always_comb begin
    addr_c = '0;
    case (access_type)
      AC_STST,
      AC_SATY: addr_c = {satb, spr_num, 2'b00};
      AC_SATX: addr_c = {satb, spr_num, 2'b01};
      AC_SATN: addr_c = {satb, spr_num, 2'b10};
      AC_SATC: addr_c = {satb, spr_num, 2'b11};
      AC_SPTH: addr_c = size1 ? {spgb, spr_name[7:2], 1'b0, spr_line}
                              : {spgb, spr_name, spr_line[2:0]};
      AC_SPTL: addr_c = {spgb, spr_name[7:2], 1'b1, spr_line};
      default: addr_c = '0;
    endcase
  end

endmodule

// File: rtl/vdp18_spr_acc.sv
// Sprite VRAM access sequencer: schedules sprite test (STST) slots during the
// active part of a line and attribute/pattern reads in the blanking region.
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   clk_en_5m37_i         : pixel enable
//   vert_inc_i            : new-line strobe; vert_active_i qualifies the line
//   num_pix_i             : signed horizontal pixel counter
//   reg_satb_i/spgb_i/size1_i : VDP registers
//   stop_sprite_i, spr_num_i, spr_line_i, spr_name_i : from sprite controller
//   access_type_o         : current access kind
//   clk_en_acc_o          : data capture strobe
//   vram_req_o, vram_a_o  : VRAM read request and address
module vdp18_spr_acc
  import vdp18_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clk_en_5m37_i,
  input  logic               vert_inc_i,
  input  logic               vert_active_i,
  input  logic signed [8:0]  num_pix_i,
  input  logic [6:0]         reg_satb_i,
  input  logic [2:0]         reg_spgb_i,
  input  logic               reg_size1_i,
  input  logic               stop_sprite_i,
  input  logic [4:0]         spr_num_i,
  input  logic [3:0]         spr_line_i,
  input  logic [7:0]         spr_name_i,
  output access_t            access_type_o,
  output logic               clk_en_acc_o,
  output logic               vram_req_o,
  output logic [13:0]        vram_a_o
);

  state_t                  state;
  phase_t                  phase;
  logic [stst_cnt_w_c-1:0] stst_cnt;
  access_t                 rd_type;

  logic                    req_c;
  access_t                 req_type_c;
  logic [vram_aw_c-1:0]    addr_c;
  logic                    test_pix_c;
  logic                    stop_acc_c;

  vdp18_spr_addr u_addr (
    .access_type (req_type_c),
    .satb        (reg_satb_i),
    .spgb        (reg_spgb_i),
    .size1       (reg_size1_i),
    .spr_num     (spr_num_i),
    .spr_line    (spr_line_i),
    .spr_name    (spr_name_i),
    .addr_c      (addr_c)
  );

  // Test slots every 8 pixels across the visible 0..255 range.
  assign test_pix_c = !num_pix_i[8] && (num_pix_i[2:0] == 3'b000);
  assign stop_acc_c = clk_en_acc_o && stop_sprite_i;

  // Slot request decision; a new slot may overlap the trailing NONE phase.
  always_comb begin
    req_c      = 1'b0;
    req_type_c = AC_NONE;
    if (clk_en_5m37_i && !vert_inc_i && (phase != PH_REQ) && !stop_acc_c) begin
      case (state)
        ST_TEST: begin
          if (test_pix_c && (stst_cnt < stst_cnt_w_c'(stst_max_c))) begin
            req_c      = 1'b1;
            req_type_c = AC_STST;
          end
        end
        ST_READ: begin
          if (!num_pix_i[0]) begin
            req_c      = 1'b1;
            req_type_c = rd_type;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, slot phase and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      phase         <= PH_FREE;
      stst_cnt      <= '0;
      rd_type       <= AC_SATY;
      access_type_o <= AC_NONE;
      clk_en_acc_o  <= 1'b0;
      vram_req_o    <= 1'b0;
      vram_a_o      <= '0;
    end else begin
      vram_req_o   <= 1'b0;
      clk_en_acc_o <= 1'b0;

      if (clk_en_5m37_i) begin
        if (req_c) begin
          access_type_o <= req_type_c;
          vram_a_o      <= addr_c;
          vram_req_o    <= 1'b1;
          phase         <= PH_REQ;
        end else begin
          case (phase)
            PH_REQ: begin
              clk_en_acc_o <= 1'b1;
              phase        <= PH_ACC;
            end
            PH_ACC: begin
              access_type_o <= AC_NONE;
              phase         <= PH_FREE;
            end
            default: ;
          endcase
        end
      end

      if (vert_inc_i) begin
        state    <= vert_active_i ? ST_TEST : ST_IDLE;
        stst_cnt <= '0;
        rd_type  <= AC_SATY;
      end else begin
        case (state)
          ST_TEST: begin
            if (req_c) begin
              stst_cnt <= stst_cnt + stst_cnt_w_c'(1);
            end
            if (clk_en_acc_o && (access_type_o == AC_STST) &&
                (stop_sprite_i || (stst_cnt == stst_cnt_w_c'(stst_max_c)))) begin
              state <= ST_WAIT_RD;
            end
          end
          ST_WAIT_RD: begin
            if (clk_en_5m37_i && (num_pix_i == hv_sprite_start_c)) begin
              state <= stop_sprite_i ? ST_DONE : ST_READ;
            end
          end
          ST_READ: begin
            if (req_c) begin
              rd_type <= read_next(req_type_c, reg_size1_i);
            end
            if (stop_acc_c) begin
              state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdp18_spr_acc.sv
// Directed bench for the sprite VRAM access sequencer.
module tb_vdp18_spr_acc;
  import vdp18_pkg::*;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               clk_en_5m37_i;
  logic               vert_inc_i;
  logic               vert_active_i;
  logic signed [8:0]  num_pix_i;
  logic [6:0]         reg_satb_i;
  logic [2:0]         reg_spgb_i;
  logic               reg_size1_i;
  logic               stop_sprite_i;
  logic [4:0]         spr_num_i;
  logic [3:0]         spr_line_i;
  logic [7:0]         spr_name_i;
  access_t            access_type_o;
  logic               clk_en_acc_o;
  logic               vram_req_o;
  logic [13:0]        vram_a_o;

  vdp18_spr_acc dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_5m37_i (clk_en_5m37_i),
    .vert_inc_i    (vert_inc_i),
    .vert_active_i (vert_active_i),
    .num_pix_i     (num_pix_i),
    .reg_satb_i    (reg_satb_i),
    .reg_spgb_i    (reg_spgb_i),
    .reg_size1_i   (reg_size1_i),
    .stop_sprite_i (stop_sprite_i),
    .spr_num_i     (spr_num_i),
    .spr_line_i    (spr_line_i),
    .spr_name_i    (spr_name_i),
    .access_type_o (access_type_o),
    .clk_en_acc_o  (clk_en_acc_o),
    .vram_req_o    (vram_req_o),
    .vram_a_o      (vram_a_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Per-line log of issued requests and controller-side bookkeeping
  logic [2:0]  lt[$];
  logic [13:0] la[$];
  int acc_cnt, stst_acc, read_acc, orphan_cnt;
  int stst_stop_at, read_stop_at;
  logic pend;
  logic rst_mode = 1'b0;
  logic rst_done = 1'b0;
  int post_req, post_acc;

  access_t exp16[6] = '{AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL};
  logic [13:0] exp16_a[6] = '{14'h1F94, 14'h1F95, 14'h1F96, 14'h1F97, 14'h3A05, 14'h3A15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] get_t(input int i);
    return (i < lt.size()) ? {1'b0, lt[i]} : 4'hF;
  endfunction

  function automatic logic [15:0] get_a(input int i);
    return (i < la.size()) ? {2'b00, la[i]} : 16'hFFFF;
  endfunction

  function automatic int count_stst();
    int n = 0;
    foreach (lt[k]) if (lt[k] == AC_STST) n++;
    return n;
  endfunction

  // One clock: observe outputs at the falling edge, act as sprite controller, drive inputs.
  task automatic cyc(input logic en, input logic vinc, input logic signed [8:0] pix);
    logic stop;
    if (vram_req_o) begin
      lt.push_back(access_type_o);
      la.push_back(vram_a_o);
      pend = 1'b1;
      if (rst_done) post_req++;
    end
    stop = 1'b0;
    if (clk_en_acc_o) begin
      acc_cnt++;
      if (!pend) orphan_cnt++;
      pend = 1'b0;
      if (rst_done) post_acc++;
      if (access_type_o == AC_STST) begin
        stst_acc++;
        if (stst_acc == stst_stop_at) stop = 1'b1;
      end else begin
        read_acc++;
        if (read_acc == read_stop_at) stop = 1'b1;
      end
    end
    stop_sprite_i = stop;
    clk_en_5m37_i = en;
    vert_inc_i    = vinc;
    num_pix_i     = pix;
    reset_i       = 1'b0;
    if (rst_mode && !rst_done && vram_req_o && (access_type_o != AC_STST)) begin
      reset_i = 1'b1;
      #1;
      check("rst_mid_type", access_type_o, AC_NONE);
      check("rst_mid_addr", vram_a_o, 0);
      check("rst_mid_req", vram_req_o, 0);
      check("rst_mid_acc", clk_en_acc_o, 0);
      rst_done = 1'b1;
      pend     = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One 384-pixel line: -8..255 then -128..-9, vert_inc at the first pixel.
  task automatic run_line(input logic active);
    int p;
    lt.delete();
    la.delete();
    acc_cnt = 0; stst_acc = 0; read_acc = 0; orphan_cnt = 0;
    post_req = 0; post_acc = 0; pend = 1'b0;
    vert_active_i = active;
    for (int i = 0; i < 384; i++) begin
      p = i - 8;
      if (p > 255) p = p - 384;
      cyc(1'b1, (i == 0), 9'(p));
      cyc(1'b0, 1'b0, 9'(p));
    end
  endtask

  task automatic cfg16();
    reg_satb_i = 7'h3F; spr_num_i = 5'd5;
    reg_size1_i = 1'b1; reg_spgb_i = 3'b111; spr_name_i = 8'h41; spr_line_i = 4'd5;
  endtask

  initial begin
    reset_i = 1'b1;
    clk_en_5m37_i = 1'b0; vert_inc_i = 1'b0; vert_active_i = 1'b0;
    num_pix_i = '0; stop_sprite_i = 1'b0;
    cfg16();
    repeat (3) @(negedge clk_i);
    check("reset_type", access_type_o, AC_NONE);
    check("reset_acc", clk_en_acc_o, 0);
    check("reset_req", vram_req_o, 0);
    check("reset_addr", vram_a_o, 0);

    // Line A: 16x16, stop on 3rd STST and after one full sprite read
    cfg16();
    stst_stop_at = 3; read_stop_at = 6;
    run_line(1'b1);
    check("A_nstst", count_stst(), 3);
    check("A_stst_type", get_t(0), AC_STST);
    check("A_stst_addr", get_a(0), 16'h1F94);
    check("A_total", lt.size(), 9);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("A_type%0d", k), get_t(3 + k), exp16[k]);
      check($sformatf("A_addr%0d", k), get_a(3 + k), exp16_a[k]);
    end
    check("A_acc", acc_cnt, 9);
    check("A_orphan", orphan_cnt, 0);
    check("A_end_none", access_type_o, AC_NONE);

    // Line B: 8x8, all 32 STSTs, stop after 6 reads (SPTH then SATY)
    reg_size1_i = 1'b0; reg_spgb_i = 3'b000; spr_name_i = 8'hFF; spr_line_i = 4'd3;
    stst_stop_at = 0; read_stop_at = 6;
    run_line(1'b1);
    check("B_nstst", count_stst(), 32);
    check("B_total", lt.size(), 38);
    check("B_spth_type", get_t(36), AC_SPTH);
    check("B_spth_addr", get_a(36), 16'h07FB);
    check("B_next_type", get_t(37), AC_SATY);
    check("B_next_addr", get_a(37), 16'h1F94);
    check("B_acc", acc_cnt, 38);
    check("B_orphan", orphan_cnt, 0);
    check("B_end_none", access_type_o, AC_NONE);

    // Line C: blank line
    stst_stop_at = 0; read_stop_at = 0;
    run_line(1'b0);
    check("C_total", lt.size(), 0);
    check("C_acc", acc_cnt, 0);

    // Line D: reset on the first read request
    cfg16();
    stst_stop_at = 3; read_stop_at = 0;
    rst_mode = 1'b1; rst_done = 1'b0;
    run_line(1'b1);
    check("D_reset_hit", rst_done, 1);
    check("D_total", lt.size(), 4);
    check("D_post_req", post_req, 0);
    check("D_post_acc", post_acc, 0);
    check("D_acc", acc_cnt, 3);
    rst_mode = 1'b0; rst_done = 1'b0;

    // Line E: normal operation after reset
    stst_stop_at = 3; read_stop_at = 6;
    run_line(1'b1);
    check("E_total", lt.size(), 9);
    check("E_sptl_type", get_t(8), AC_SPTL);
    check("E_sptl_addr", get_a(8), 16'h3A15);
    check("E_acc", acc_cnt, 9);
    check("E_end_none", access_type_o, AC_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vdp18_spr_acc.md
VDP18_SPR_ACC -- requirements
Module: vdp18_spr_acc

Interface
REQ-001 SHALL have clk_i  in  1  system clock.
REQ-002 SHALL have reset_i  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have clk_en_5m37_i  in  1  pixel clock enable, one clk_i cycle per pixel.
REQ-004 SHALL have vert_inc_i  in  1  single-cycle new-line strobe.
REQ-005 SHALL have vert_active_i  in  1  current line is inside the active display.
REQ-006 SHALL have num_pix_i  in  9 signed  horizontal pixel counter.
REQ-007 SHALL have reg_satb_i  in  7  sprite attribute table base (VRAM A[0:6]).
REQ-008 SHALL have reg_spgb_i  in  3  sprite pattern generator base (VRAM A[0:2]).
REQ-009 SHALL have reg_size1_i  in  1  16x16 sprites.
REQ-010 SHALL have stop_sprite_i, spr_num_i[5], spr_line_i[4], spr_name_i[8]  in  from sprite controller.
REQ-011 SHALL have access_type_o  out  access_t  current sprite access type.
REQ-012 SHALL have clk_en_acc_o  out  1  data-capture strobe for the sprite controller.
REQ-013 SHALL have vram_req_o  out  1  single-cycle VRAM read request.
REQ-014 SHALL have vram_a_o  out  14  VRAM address.

Function
REQ-015 States: IDLE, TEST, WAIT_RD, READ, DONE.
REQ-016 A slot SHALL be defined as follows: on a clk_en_5m37_i cycle, latch access_type_o and vram_a_o, and pulse vram_req_o. On the next clk_en_5m37_i cycle, pulse clk_en_acc_o. On the enable cycle after that, return access_type_o to AC_NONE.
REQ-017 vert_inc_i SHALL force TEST if vert_active_i=1, else IDLE. This SHALL take priority over all other transitions.
REQ-018 TEST: issue AC_STST slots where num_pix_i in 0..255 and num_pix_i[6:8]=000 (max 32 per line).
REQ-019 TEST -> WAIT_RD when stop_sprite_i=1 during an STST clk_en_acc_o cycle, or after the 32nd STST.
REQ-020 WAIT_RD -> READ at num_pix_i==hv_sprite_start_c, unless stop_sprite_i=1 in that cycle, in which case -> DONE.
REQ-021 READ: issue slots on even num_pix_i, with per-sprite order SATY, SATX, SATN, SATC, SPTH, SPTL. SPTL SHALL be omitted when reg_size1_i=0.
REQ-022 READ -> DONE when stop_sprite_i=1 on a clk_en_acc_o cycle. DONE SHALL issue no slots until vert_inc_i.
REQ-023 Addresses:
  - STST/SATY: {satb, spr_num, 00}
  - SATX: {satb, spr_num, 01}
  - SATN: {satb, spr_num, 10}
  - SATC: {satb, spr_num, 11}
REQ-024 Pattern addresses with reg_size1_i=0: SPTH = {spgb, name[0:7], line[1:3]}.
REQ-025 Pattern addresses with reg_size1_i=1: SPTH = {spgb, name[0:5], 0, line}; SPTL = {spgb, name[0:5], 1, line}.
REQ-026 Address fields SHALL be sampled from spr_* inputs in the request cycle.
REQ-027 reg_* changes SHALL take effect at the next slot.
REQ-028 The slot counter SHALL NOT wrap. A 33rd STST is never issued.
REQ-029 clk_en_acc_o SHALL never assert without a preceding vram_req_o in the same slot.

Reset
REQ-030 On reset_i, all outputs SHALL go immediately to: access_type_o=AC_NONE, clk_en_acc_o=0, vram_req_o=0, vram_a_o=0. State SHALL go to IDLE and the slot counter SHALL be cleared.
REQ-031 Reset mid-slot SHALL suppress that slot's clk_en_acc_o. Normal operation SHALL resume at the next vert_inc_i.

Structure
REQ-032 access_t, hv_sprite_start_c, and the state enum SHALL reside in vdp18_pkg.
REQ-033 Address formation SHALL be a combinational sub-module vdp18_spr_addr.

Verification
REQ-034 Reset: assert reset_i mid-READ -> access_type_o=AC_NONE, vram_a_o=0, no clk_en_acc_o; the next line behaves normally.
REQ-035 STST address: satb=7'h3F, spr_num=5 -> vram_a_o=14'h1F94, access_type_o=AC_STST.
REQ-036 Early stop: stop_sprite_i on the 3rd STST capture -> exactly 3 STST slots on that line.
REQ-037 16x16 read: reg_size1_i=1, spgb=3'b111, name=8'h41, line=5 -> SPTH 14'h3A05 then SPTL 14'h3A15, with order SATY..SPTL.
REQ-038 8x8 read: reg_size1_i=0, spgb=0, name=8'hFF, line=3 -> SPTH 14'h07FB, then no SPTL; the next access is SATY.
REQ-039 Blank line: vert_active_i=0 at vert_inc_i -> zero slots for the whole line.
